// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the RV32I writeback stage and register file.
//   XLEN       : data width of registers and writeback paths
//   REG_IDX_W  : register index width
//   NREGS      : architectural register count
//   ZERO_REG   : index of the hard-wired zero register
//   wb_sel_e   : writeback source select encoding
package wb_regfile_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NREGS     = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // Kept as an enum so PC+4 can be added as a third source later
  typedef enum logic [0:0] {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

endpackage

// File: rtl/wb_mux.sv
// Writeback source selector.
//   sel : source select (WB_SEL_ALU / WB_SEL_MEM)
//   alu : ALU result
//   mem : load data
//   y   : selected writeback value (combinational)
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int W = 32
) (
  input  wb_sel_e        sel,
  input  logic [W-1:0]   alu,
  input  logic [W-1:0]   mem,
  output logic [W-1:0]   y
);

  always_comb begin
    y = alu;
    case (sel)
      WB_SEL_ALU: y = alu;
      WB_SEL_MEM: y = mem;
      default:    y = alu;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and architectural register file for the RV32I core.
//   clk, rst   : core clock, asynchronous active-high reset
//   regWriteIn : writeback enable from EX/WB
//   MemToRegIn : 1 = commit memIn, 0 = commit aluIn
//   rdIn       : destination register index
//   aluIn      : ALU result
//   memIn      : load data
//   retireIn   : one instruction retires this cycle
//   rs1, rs2   : read port addresses
//   rd1, rd2   : read port data (combinational, optional write bypass)
//   wbData     : selected writeback value (combinational)
//   instret    : retired-instruction counter
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regWriteIn,
  input  logic                 MemToRegIn,
  input  logic [REG_IDX_W-1:0] rdIn,
  input  logic [XLEN-1:0]      aluIn,
  input  logic [XLEN-1:0]      memIn,
  input  logic                 retireIn,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic [XLEN-1:0]      rd1,
  output logic [XLEN-1:0]      rd2,
  output logic [XLEN-1:0]      wbData,
  output logic [CNT_W-1:0]     instret
);

  localparam int NSLOTS = 2 ** REG_IDX_W;

  // Full index space is declared; slots at or above NREGS and slot 0 are
  // never written, so they stay at their reset value of zero.
  logic [XLEN-1:0] regs [NSLOTS];
  logic            commit;
  wb_sel_e         wb_sel;

  function automatic logic live_idx(input logic [REG_IDX_W-1:0] idx);
    return (idx != ZERO_REG) && (int'(idx) < NREGS);
  endfunction

  function automatic logic [XLEN-1:0] read_port(
    input logic [REG_IDX_W-1:0] rs,
    input logic                 in_reset,
    input logic                 wr_en,
    input logic [REG_IDX_W-1:0] wr_idx,
    input logic [XLEN-1:0]      wr_data,
    input logic [XLEN-1:0]      stored
  );
    if (in_reset || !live_idx(rs))
      return '0;
    else if (BYPASS && wr_en && (wr_idx == rs))
      return wr_data;
    else
      return stored;
  endfunction

  assign wb_sel = MemToRegIn ? WB_SEL_MEM : WB_SEL_ALU;

  wb_mux #(.W(XLEN)) u_wb_mux (
    .sel (wb_sel),
    .alu (aluIn),
    .mem (memIn),
    .y   (wbData)
  );

  assign commit = regWriteIn && live_idx(rdIn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSLOTS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rdIn] <= wbData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      instret <= '0;
    else if (retireIn)
      instret <= instret + CNT_W'(1);
  end

  // Explicit rst gating keeps the bypass from leaking wbData during reset
  assign rd1 = read_port(rs1, rst, regWriteIn, rdIn, wbData, regs[rs1]);
  assign rd2 = read_port(rs2, rst, regWriteIn, rdIn, wbData, regs[rs2]);

endmodule
